// File: rtl/fixed_point_pkg.sv
// Shared constants and helpers for the fixed-point multiply-accumulate pipeline.
// Widths derive from the operand format; the saturating add works on a wide
// carrier and clamps to any accumulator width up to SAT_W-1 bits.
package fixed_point_pkg;

  localparam int DEF_WII   = 8;
  localparam int DEF_WIF   = 8;
  localparam int DEF_WOI   = 8;
  localparam int DEF_WOF   = 8;
  localparam int DEF_GUARD = 4;

  // Carrier width for sat_add; accumulators must stay narrower than this so the
  // raw sum of two in-range values can never wrap inside the carrier.
  localparam int SAT_W = 64;

  function automatic int prod_width(input int wii, input int wif);
    return 2 * (wii + wif);
  endfunction

  function automatic int acc_width(input int wii, input int wif, input int guard);
    return 2 * (wii + wif) + guard;
  endfunction

  // Largest positive value representable in a w-bit two's complement word.
  function automatic logic signed [SAT_W-1:0] acc_max(input int w);
    return $signed((SAT_W'(1) << (w - 1)) - SAT_W'(1));
  endfunction

  // Most negative value representable in a w-bit two's complement word.
  function automatic logic signed [SAT_W-1:0] acc_min(input int w);
    return ~acc_max(w);
  endfunction

  localparam int PROD_W = prod_width(DEF_WII, DEF_WIF);
  localparam int ACC_W  = acc_width(DEF_WII, DEF_WIF, DEF_GUARD);
  localparam logic signed [SAT_W-1:0] ACC_MAX = acc_max(ACC_W);
  localparam logic signed [SAT_W-1:0] ACC_MIN = acc_min(ACC_W);

  // Signed add of two w-bit values (sign-extended into the carrier), clamped to
  // the w-bit range instead of wrapping.
  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int                      w
  );
    logic signed [SAT_W-1:0] sum;
    sum = a + b;
    if (sum > acc_max(w)) return acc_max(w);
    if (sum < acc_min(w)) return acc_min(w);
    return sum;
  endfunction

endpackage

// File: rtl/fixed_point_mac_acc_if.sv
// Valid-only operand stream in, frame result out, for fixed_point_mac_acc.
interface fixed_point_mac_acc_if #(
  parameter int WII = 8,
  parameter int WIF = 8,
  parameter int WOI = 8,
  parameter int WOF = 8
);
  logic                 i_valid;
  logic                 i_last;
  logic [WII+WIF-1:0]   i_x;
  logic [WII+WIF-1:0]   i_y;
  logic                 o_valid;
  logic [WOI+WOF-1:0]   o_sum;
  logic                 o_upflow;
  logic                 o_downflow;

  // Producer side: drives operands, observes frame results.
  modport master (
    output i_valid, i_last, i_x, i_y,
    input  o_valid, o_sum, o_upflow, o_downflow
  );

  // MAC side.
  modport slave (
    input  i_valid, i_last, i_x, i_y,
    output o_valid, o_sum, o_upflow, o_downflow
  );
endinterface

// File: rtl/fixed_point_mac_acc_zoom.sv
// comb_FixedPointZoom: combinational signed WII.WIF -> WOI.WOF format conversion.
// Fraction is widened with zeros or narrowed by truncation toward -inf, or by
// round half-up when ROUND is set. Integer overflow raises o_upflow/o_downflow;
// with ROOF set the result clamps, otherwise the low output bits pass through.
module comb_FixedPointZoom #(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROOF  = 1,
  parameter int ROUND = 1
) (
  input  logic [WII+WIF-1:0] i_data,
  output logic [WOI+WOF-1:0] o_data,
  output logic               o_upflow,
  output logic               o_downflow
);
  localparam int IW = WII + WIF;
  localparam int OW = WOI + WOF;
  // Input integer bits, output fraction bits, plus one for a rounding carry.
  localparam int AW = WII + WOF + 1;
  localparam int CW = ((AW > OW) ? AW : OW) + 1;

  localparam logic signed [CW-1:0] OMAX = {{(CW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [CW-1:0] OMIN = {{(CW-OW+1){1'b1}}, {(OW-1){1'b0}}};

  logic signed [AW-1:0] aligned;
  logic signed [CW-1:0] wide;
  logic                 up;
  logic                 dn;

  generate
    if (WOF >= WIF) begin : g_widen
      assign aligned = AW'($signed({i_data[IW-1], i_data})) <<< (WOF - WIF);
    end else begin : g_narrow
      localparam int DROP = WIF - WOF;
      localparam logic [IW:0] HALF = (ROUND != 0) ? ((IW+1)'(1) << (DROP - 1)) : '0;
      logic signed [IW:0] biased;
      assign biased  = $signed({i_data[IW-1], i_data}) + $signed(HALF);
      assign aligned = AW'(biased >>> DROP);
    end
  endgenerate

  assign wide = CW'(aligned);

  // Range check against the output format, then clamp or pass the low bits.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    up     = (wide > OMAX);
    dn     = (wide < OMIN);
    o_data = wide[OW-1:0];
    if (ROOF != 0 && up)      o_data = {1'b0, {(OW-1){1'b1}}};
    else if (ROOF != 0 && dn) o_data = {1'b1, {(OW-1){1'b0}}};
  end

  assign o_upflow   = up;
  assign o_downflow = dn;
endmodule

// File: rtl/fixed_point_mac_acc.sv
// Three-stage signed fixed-point MAC: multiply, saturating frame accumulate,
// then format conversion of the frame sum. One pair per cycle, no backpressure,
// frames delimited by i_last, result pulse three cycles after the last pair.
module fixed_point_mac_acc
  import fixed_point_pkg::*;
#(
  parameter int WII   = DEF_WII,
  parameter int WIF   = DEF_WIF,
  parameter int WOI   = DEF_WOI,
  parameter int WOF   = DEF_WOF,
  parameter int GUARD = DEF_GUARD,
  parameter int ROOF  = 1,
  parameter int ROUND = 1
) (
  input logic                  clk,
  input logic                  rstn,
  fixed_point_mac_acc_if.slave bus
);
  localparam int PW = prod_width(WII, WIF);
  localparam int AW = acc_width(WII, WIF, GUARD);
  localparam int OW = WOI + WOF;

  logic                 s1_valid;
  logic                 s1_last;
  logic signed [PW-1:0] s1_prod;
  logic                 first_flag;
  logic                 s2_done;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic [OW-1:0]        zoom_sum;
  logic                 zoom_up;
  logic                 zoom_dn;

  // Stage 1 control: sample valid and frame end (last only counts with valid).
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: registered state is assigned with <= so every flop samples pre-edge values.
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= bus.i_valid;
      s1_last  <= bus.i_valid & bus.i_last;
    end
  end

  // Stage 1 datapath: exact signed product in 2WII.2WIF.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers have no reset; each consumer is gated by a valid that does.
    if (bus.i_valid) s1_prod <= $signed(bus.i_x) * $signed(bus.i_y);
  end

  // Next accumulator: restart from the product on a frame's first sample,
  // otherwise add with clamping so a long frame pins instead of wrapping.
  always_comb begin
    acc_next = AW'(s1_prod);
    if (!first_flag) acc_next = AW'(sat_add(SAT_W'(acc), SAT_W'(s1_prod), AW));
  end

  // Stage 2 control: track frame start and flag a completed frame sum.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      first_flag <= 1'b1;
      s2_done    <= 1'b0;
    end else begin
      s2_done <= s1_last;
      if (s1_valid) first_flag <= s1_last;
    end
  end

  // Stage 2 datapath: accumulator holds across idle gaps.
  always_ff @(posedge clk) begin
    if (s1_valid) acc <= acc_next;
  end

  comb_FixedPointZoom #(
    .WII  (2 * WII + GUARD),
    .WIF  (2 * WIF),
    .WOI  (WOI),
    .WOF  (WOF),
    .ROOF (ROOF),
    .ROUND(ROUND)
  ) u_zoom (
    .i_data    (acc),
    .o_data    (zoom_sum),
    .o_upflow  (zoom_up),
    .o_downflow(zoom_dn)
  );

  // Stage 3: register the converted frame sum and pulse o_valid; hold otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.o_valid    <= 1'b0;
      bus.o_sum      <= '0;
      bus.o_upflow   <= 1'b0;
      bus.o_downflow <= 1'b0;
    end else begin
      bus.o_valid <= s2_done;
      if (s2_done) begin
        bus.o_sum      <= zoom_sum;
        bus.o_upflow   <= zoom_up;
        bus.o_downflow <= zoom_dn;
      end
    end
  end
endmodule

// File: tb/tb_fixed_point_mac_acc.sv
// Bench for fixed_point_mac_acc: three instances (default; ROOF=0/ROUND=0;
// GUARD=1) share one stimulus stream and are compared against a frame-level
// arithmetic model of multiply, clamp-accumulate and output conversion.
module tb_fixed_point_mac_acc;
  localparam int NCFG = 3;
  localparam int CFG_GUARD [NCFG] = '{4, 4, 1};
  localparam int CFG_ROOF  [NCFG] = '{1, 0, 1};
  localparam int CFG_ROUND [NCFG] = '{1, 0, 1};
  localparam int DROP = 8;  // product has 16 fraction bits, output keeps 8

  typedef struct packed { logic [15:0] sum; logic up; logic dn; } res_t;
  typedef struct packed { int due; res_t [NCFG-1:0] r; } pend_t;

  logic clk = 1'b0;
  logic rstn;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  longint acc_m   [NCFG];
  bit     first_m [NCFG];
  res_t   held    [NCFG];
  pend_t  pend    [$];

  logic        ov [NCFG];
  logic [15:0] os [NCFG];
  logic        ou [NCFG];
  logic        od [NCFG];

  fixed_point_mac_acc_if #(.WII(8), .WIF(8), .WOI(8), .WOF(8)) bus0 ();
  fixed_point_mac_acc_if #(.WII(8), .WIF(8), .WOI(8), .WOF(8)) bus1 ();
  fixed_point_mac_acc_if #(.WII(8), .WIF(8), .WOI(8), .WOF(8)) bus2 ();

  fixed_point_mac_acc #(.WII(8), .WIF(8), .WOI(8), .WOF(8), .GUARD(CFG_GUARD[0]),
    .ROOF(CFG_ROOF[0]), .ROUND(CFG_ROUND[0])) dut0 (.clk(clk), .rstn(rstn), .bus(bus0));
  fixed_point_mac_acc #(.WII(8), .WIF(8), .WOI(8), .WOF(8), .GUARD(CFG_GUARD[1]),
    .ROOF(CFG_ROOF[1]), .ROUND(CFG_ROUND[1])) dut1 (.clk(clk), .rstn(rstn), .bus(bus1));
  fixed_point_mac_acc #(.WII(8), .WIF(8), .WOI(8), .WOF(8), .GUARD(CFG_GUARD[2]),
    .ROOF(CFG_ROOF[2]), .ROUND(CFG_ROUND[2])) dut2 (.clk(clk), .rstn(rstn), .bus(bus2));

  assign ov[0] = bus0.o_valid;  assign os[0] = bus0.o_sum;
  assign ou[0] = bus0.o_upflow; assign od[0] = bus0.o_downflow;
  assign ov[1] = bus1.o_valid;  assign os[1] = bus1.o_sum;
  assign ou[1] = bus1.o_upflow; assign od[1] = bus1.o_downflow;
  assign ov[2] = bus2.o_valid;  assign os[2] = bus2.o_sum;
  assign ou[2] = bus2.o_upflow; assign od[2] = bus2.o_downflow;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: clamp a frame sum to the accumulator range of a configuration.
  function automatic longint clamp_acc(input longint v, input int c);
    longint mx;
    longint mn;
    mx = (longint'(1) <<< (31 + CFG_GUARD[c])) - 1;
    mn = -mx - 1;
    if (v > mx) return mx;
    if (v < mn) return mn;
    return v;
  endfunction

  // Reference: convert a Q.16 frame sum to Q8.8 with optional rounding/clamping.
  function automatic res_t zoom_model(input longint a, input int c);
    longint q;
    res_t   r;
    q = (CFG_ROUND[c] != 0) ? ((a + (longint'(1) <<< (DROP - 1))) >>> DROP) : (a >>> DROP);
    r.up  = (q > 32767);
    r.dn  = (q < -32768);
    r.sum = q[15:0];
    if (CFG_ROOF[c] != 0 && r.up) r.sum = 16'h7FFF;
    if (CFG_ROOF[c] != 0 && r.dn) r.sum = 16'h8000;
    return r;
  endfunction

  task automatic model_reset();
    pend.delete();
    for (int c = 0; c < NCFG; c++) begin
      acc_m[c]   = 0;
      first_m[c] = 1'b1;
      held[c]    = '0;
    end
  endtask

  task automatic model_sample(input logic l, input logic [15:0] x, input logic [15:0] y);
    longint p;
    pend_t  e;
    p = longint'($signed(x)) * longint'($signed(y));
    e.due = cyc + 2;
    for (int c = 0; c < NCFG; c++) begin
      acc_m[c]   = first_m[c] ? p : clamp_acc(acc_m[c] + p, c);
      first_m[c] = l;
      e.r[c]     = zoom_model(acc_m[c], c);
    end
    if (l) pend.push_back(e);
  endtask

  task automatic drive(input logic v, input logic l, input logic [15:0] x, input logic [15:0] y);
    bus0.i_valid = v; bus0.i_last = l; bus0.i_x = x; bus0.i_y = y;
    bus1.i_valid = v; bus1.i_last = l; bus1.i_x = x; bus1.i_y = y;
    bus2.i_valid = v; bus2.i_last = l; bus2.i_x = x; bus2.i_y = y;
  endtask

  task automatic check_outputs();
    logic expv;
    expv = (pend.size() > 0) && (pend[0].due == cyc);
    for (int c = 0; c < NCFG; c++) begin
      if (expv) held[c] = pend[0].r[c];
      check($sformatf("o_valid cfg%0d cyc%0d", c, cyc), 32'(ov[c]), 32'(expv));
      check($sformatf("o_sum cfg%0d cyc%0d", c, cyc), 32'(os[c]), 32'(held[c].sum));
      check($sformatf("up/down cfg%0d cyc%0d", c, cyc), 32'({ou[c], od[c]}),
            32'({held[c].up, held[c].dn}));
    end
    if (expv) void'(pend.pop_front());
  endtask

  // One clock: present inputs, update the model at the edge, check just after.
  task automatic tick(input logic v, input logic l, input logic [15:0] x, input logic [15:0] y);
    drive(v, l, x, y);
    @(posedge clk);
    cyc++;
    if (rstn && v) model_sample(l, x, y);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  function automatic logic [15:0] rand_op();
    if ($urandom_range(1, 0) == 1) return 16'($urandom);
    return 16'($urandom_range(2047, 0)) - 16'd1024;
  endfunction

  int len;

  initial begin
    rstn = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    model_reset();
    #1;
    check_outputs();
    repeat (2) @(posedge clk);
    cyc += 2;
    #1 rstn = 1'b1;

    // Single-pair frame: 1.5 * 2.0 = 3.0.
    tick(1'b1, 1'b1, 16'h0180, 16'h0200);
    idle(3);

    // Four 1.0*1.0 pairs with a two-cycle gap inside the frame.
    tick(1'b1, 1'b0, 16'h0100, 16'h0100);
    tick(1'b1, 1'b0, 16'h0100, 16'h0100);
    idle(2);
    tick(1'b1, 1'b0, 16'h0100, 16'h0100);
    tick(1'b1, 1'b1, 16'h0100, 16'h0100);
    idle(4);

    // Output overflow in both directions, back to back.
    tick(1'b1, 1'b1, 16'h6400, 16'h6400);
    tick(1'b1, 1'b1, 16'h9C00, 16'h6400);
    idle(3);

    // Rounding of +1/512 and -1/512.
    tick(1'b1, 1'b1, 16'h0001, 16'h0080);
    tick(1'b1, 1'b1, 16'hFFFF, 16'h0080);
    idle(3);

    // Back-to-back frames, no carry-over; last without valid is ignored.
    tick(1'b0, 1'b1, 16'h0100, 16'h0100);
    tick(1'b1, 1'b1, 16'h0100, 16'h0100);
    tick(1'b1, 1'b1, 16'h0200, 16'h0100);
    idle(3);

    // Long frames driving the accumulator into its clamp, positive then negative.
    for (int i = 0; i < 8; i++) tick(1'b1, 1'(i == 7), 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < 8; i++) tick(1'b1, 1'(i == 7), 16'h8000, 16'h7FFF);
    idle(3);

    // Randomised frames with random gaps.
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(6, 1);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(3, 0) == 0) tick(1'b0, 1'($urandom_range(1, 0)), rand_op(), rand_op());
        tick(1'b1, 1'(k == len - 1), rand_op(), rand_op());
      end
    end
    idle(3);

    // Reset mid-frame: outputs clear at once and the partial sum is discarded.
    tick(1'b1, 1'b0, 16'h1000, 16'h1000);
    tick(1'b1, 1'b0, 16'h1000, 16'h1000);
    rstn = 1'b0;
    #1;
    for (int c = 0; c < NCFG; c++)
      check($sformatf("async reset outputs cfg%0d", c), 32'({ov[c], os[c], ou[c], od[c]}), 32'd0);
    model_reset();
    drive(1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    cyc++;
    #1 rstn = 1'b1;
    tick(1'b1, 1'b0, 16'h0100, 16'h0300);
    tick(1'b1, 1'b1, 16'h0100, 16'h0100);
    idle(4);

    check("pending results drained", 32'(pend.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
